jogo_cl_multijogador: RTL

//  Parametrised, turn-based successor of the single-player chess-square game core.

---
 rtl/jogo_cl_multijogador.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/jogo_cl_multijogador.sv
// jogo_cl_multijogador: turn-based multiplayer chess-square game core.
// The FSM shows a square drawn from an 8-bit LFSR. The active player names it
// before their turn timer expires. A hit scores one BCD point and draws a new
// square. A miss costs PENALIDADE seconds and keeps the same square.
module jogo_cl_multijogador #(
    parameter int         NUM_JOGADORES  = 2,
    parameter int         TAM_TABULEIRO  = 8,
    parameter int         TEMPO_INICIAL  = 30,
    parameter int         CICLOS_POR_SEG = 1000,
    parameter int         PENALIDADE     = 3,
    parameter logic [7:0] SEMENTE        = 8'hA5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         iniciar,
    input  logic                         terminar,
    input  logic                         temJogada,
    input  logic [3:0]                   jogadaFileira,
    input  logic [3:0]                   jogadaColuna,
    output logic [3:0]                   linhaEsperada,
    output logic [3:0]                   colunaEsperada,
    output logic [1:0]                   jogadorAtual,
    output logic [8*NUM_JOGADORES-1:0]   pontos,
    output logic [7:0]                   tempoRestante,
    output logic                         acertou,
    output logic                         errou,
    output logic                         fimJogo,
    output logic [3:0]                   db_estado
);
    localparam int                 PRESC_W   = $clog2(CICLOS_POR_SEG);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CICLOS_POR_SEG - 1);
    localparam logic [7:0]         TEMPO_INI = 8'(TEMPO_INICIAL);
    localparam logic [7:0]         PENAL     = 8'(PENALIDADE);
    localparam logic [1:0]         ULTIMO    = 2'(NUM_JOGADORES - 1);
    localparam logic [4:0]         TAM5      = 5'(TAM_TABULEIRO);

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        PREPARA = 4'd1,
        GERA    = 4'd2,
        ESPERA  = 4'd3,
        COMPARA = 4'd4,
        ACERTO  = 4'd5,
        ERRO    = 4'd6,
        PROX    = 4'd7,
        FIM     = 4'd15
    } estado_t;

    estado_t            estado;
    logic [7:0]         lfsr;
    logic               temJogadaAnt;
    logic [3:0]         fileiraLida;
    logic [3:0]         colunaLida;
    logic [PRESC_W-1:0] prescaler;
    logic [7:0]         placar [NUM_JOGADORES];

    logic [3:0]         novaLinha;
    logic [3:0]         colunaBase;
    logic [3:0]         novaColuna;
    logic               borda;
    logic               realimentacao;
    logic               acerto;

    // Reduce a value onto the board (0..TAM-1).
    function automatic logic [3:0] modTab(input logic [4:0] v);
        return 4'(int'(v) % TAM_TABULEIRO);
    endfunction

    // BCD increment that stops at 99.
    function automatic logic [7:0] incBcdSat(input logic [7:0] v);
        if (v == 8'h99)
            return v;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Subtraction clamped at zero.
    function automatic logic [7:0] subSat(input logic [7:0] v, input logic [7:0] d);
        return (v > d) ? v - d : 8'd0;
    endfunction

    assign borda         = temJogada & ~temJogadaAnt;
    assign realimentacao = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign db_estado     = estado;

    for (genvar p = 0; p < NUM_JOGADORES; p++) begin : gPontos
        assign pontos[8*p +: 8] = placar[p];
    end

    // Next target from the LFSR, nudged one column if it would repeat the current one.
    always_comb begin
        novaLinha  = modTab({1'b0, lfsr[3:0]});
        colunaBase = modTab({1'b0, lfsr[7:4]});
        novaColuna = colunaBase;
        if (novaLinha == linhaEsperada && colunaBase == colunaEsperada)
            novaColuna = modTab({1'b0, colunaBase} + 5'd1);
    end

    // A move hits only on an on-board exact match with the shown square.
    always_comb begin
        acerto = ({1'b0, fileiraLida} < TAM5) && ({1'b0, colunaLida} < TAM5)
              && (fileiraLida == linhaEsperada) && (colunaLida == colunaEsperada);
    end

    // Game FSM with its LFSR, move-edge register, timer and scoreboard.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado         <= INICIAL;
            lfsr           <= SEMENTE;
            temJogadaAnt   <= 1'b0;
            fileiraLida    <= 4'd0;
            colunaLida     <= 4'd0;
            prescaler      <= '0;
            linhaEsperada  <= 4'd0;
            colunaEsperada <= 4'd0;
            jogadorAtual   <= 2'd0;
            tempoRestante  <= 8'd0;
            acertou        <= 1'b0;
            errou          <= 1'b0;
            fimJogo        <= 1'b0;
            for (int p = 0; p < NUM_JOGADORES; p++)
                placar[p] <= 8'd0;
        end else begin
            lfsr         <= {lfsr[6:0], realimentacao};
            temJogadaAnt <= temJogada;
            acertou      <= 1'b0;
            errou        <= 1'b0;
            case (estado)
                INICIAL: begin
                    if (iniciar)
                        estado <= PREPARA;
                end
                PREPARA: begin
                    for (int p = 0; p < NUM_JOGADORES; p++)
                        placar[p] <= 8'd0;
                    jogadorAtual  <= 2'd0;
                    tempoRestante <= TEMPO_INI;
                    prescaler     <= '0;
                    estado        <= GERA;
                end
                GERA: begin
                    linhaEsperada  <= novaLinha;
                    colunaEsperada <= novaColuna;
                    estado         <= ESPERA;
                end
                ESPERA: begin
                    // The second counter runs only while the player is thinking.
                    if (prescaler == PRESC_MAX) begin
                        prescaler <= '0;
                        if (tempoRestante != 8'd0)
                            tempoRestante <= tempoRestante - 8'd1;
                    end else begin
                        prescaler <= prescaler + PRESC_W'(1);
                    end
                    if (terminar) begin
                        fimJogo <= 1'b1;
                        estado  <= FIM;
                    end else if (tempoRestante == 8'd0) begin
                        estado <= PROX;
                    end else if (borda) begin
                        fileiraLida <= jogadaFileira;
                        colunaLida  <= jogadaColuna;
                        estado      <= COMPARA;
                    end
                end
                COMPARA: begin
                    if (acerto) begin
                        acertou <= 1'b1;
                        estado  <= ACERTO;
                    end else begin
                        errou  <= 1'b1;
                        estado <= ERRO;
                    end
                end
                ACERTO: begin
                    for (int p = 0; p < NUM_JOGADORES; p++)
                        if (jogadorAtual == 2'(p))
                            placar[p] <= incBcdSat(placar[p]);
                    estado <= GERA;
                end
                ERRO: begin
                    tempoRestante <= subSat(tempoRestante, PENAL);
                    estado        <= ESPERA;
                end
                PROX: begin
                    if (jogadorAtual == ULTIMO) begin
                        fimJogo <= 1'b1;
                        estado  <= FIM;
                    end else begin
                        jogadorAtual  <= jogadorAtual + 2'd1;
                        tempoRestante <= TEMPO_INI;
                        prescaler     <= '0;
                        estado        <= GERA;
                    end
                end
                FIM: begin
                    if (iniciar) begin
                        fimJogo <= 1'b0;
                        estado  <= PREPARA;
                    end
                end
                default: estado <= INICIAL;
            endcase
        end
    end
endmodule
